// File: rtl/lsu_pkg.sv
// Shared encodings and helpers for the load/store unit.
// Pure declarations: no latency or flow control of its own.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        WRITE  = 2'b10,
        RESP   = 2'b11
    } lsu_state_t;

    // Illegal size encodings are folded in here so callers see a single error term.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_BYTE: misaligned = 1'b0;
            SZ_HALF: misaligned = off[0];
            SZ_WORD: misaligned = (off != 2'b00);
            default: misaligned = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Little-endian lane extract (with sign/zero extension) and lane merge for sub-word access.
// Purely combinational, zero latency, no flow control.
module lsu_byte_lane
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        sgn,
    output logic [31:0] load_val,
    output logic [31:0] merge_val
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = 8'(word >> {offset, 3'b000});
        lane_h = offset[1] ? word[31:16] : word[15:0];

        case (size)
            SZ_BYTE: load_val = {{24{sgn & lane_b[7]}}, lane_b};
            SZ_HALF: load_val = {{16{sgn & lane_h[15]}}, lane_h};
            SZ_WORD: load_val = word;
            default: load_val = 32'd0;
        endcase

        merge_val = word;
        case (size)
            SZ_BYTE: merge_val[{offset, 3'b000} +: 8] = wdata[7:0];
            SZ_HALF: begin
                if (offset[1]) merge_val[31:16] = wdata[15:0];
                else           merge_val[15:0]  = wdata[15:0];
            end
            SZ_WORD: merge_val = wdata;
            default: merge_val = word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Byte/half/word load-store master for a word-indexed memory; optional counters under LSU_PERF_CNT_EN.
// Latency load/word-store 2, sub-word store 3, error 1; one outstanding request, req_ready low while busy.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DEPTH = 100,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [1:0]    req_size,
    input  logic          req_signed,
    input  logic [AW-1:0] req_addr,
    input  logic [31:0]   req_wdata,
    output logic          rsp_valid,
    output logic [31:0]   rsp_rdata,
    output logic          rsp_err,
    output logic [AW-1:0] mem_A,
    output logic [31:0]   mem_WD,
    output logic          mem_WE,
    input  logic [31:0]   mem_RD
`ifdef LSU_PERF_CNT_EN
    ,
    output logic [15:0]   load_cnt,
    output logic [15:0]   store_cnt,
    output logic [15:0]   err_cnt
`endif
);

    lsu_state_t    state_q;
    logic          we_q;
    logic [1:0]    size_q;
    logic          sgn_q;
    logic [1:0]    off_q;
    logic [31:0]   wdata_q;
    logic          wr_q;

    logic [AW-1:0] widx;
    logic          req_bad;
    logic          accept;
    logic [31:0]   load_val;
    logic [31:0]   merge_val;

    assign widx      = req_addr >> 2;
    assign req_bad   = misaligned(req_size, req_addr[1:0]) || (widx >= AW'(DEPTH));
    assign req_ready = (state_q == IDLE) && !rst;
    assign accept    = req_valid && req_ready;
    // Gating by rst keeps a reset that lands in WRITE from committing a half-merged word.
    assign mem_WE    = wr_q && !rst;

    lsu_byte_lane u_lane (
        .word      (mem_RD),
        .wdata     (wdata_q),
        .offset    (off_q),
        .size      (size_q),
        .sgn       (sgn_q),
        .load_val  (load_val),
        .merge_val (merge_val)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            we_q      <= 1'b0;
            size_q    <= SZ_BYTE;
            sgn_q     <= 1'b0;
            off_q     <= 2'b00;
            wdata_q   <= 32'd0;
            wr_q      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
            mem_A     <= '0;
            mem_WD    <= 32'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        we_q    <= req_we;
                        size_q  <= req_size;
                        sgn_q   <= req_signed;
                        off_q   <= req_addr[1:0];
                        wdata_q <= req_wdata;
                        if (req_bad) begin
                            state_q   <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= 32'd0;
                        end else begin
                            state_q <= ACCESS;
                            mem_A   <= widx;
                            // Full-word stores need no read, so they write during ACCESS.
                            if (req_we && req_size == SZ_WORD) begin
                                wr_q   <= 1'b1;
                                mem_WD <= req_wdata;
                            end
                        end
                    end
                end
                ACCESS: begin
                    if (!we_q) begin
                        rsp_rdata <= load_val;
                        rsp_valid <= 1'b1;
                        state_q   <= RESP;
                    end else if (size_q == SZ_WORD) begin
                        wr_q      <= 1'b0;
                        rsp_valid <= 1'b1;
                        state_q   <= RESP;
                    end else begin
                        mem_WD  <= merge_val;
                        wr_q    <= 1'b1;
                        state_q <= WRITE;
                    end
                end
                WRITE: begin
                    wr_q      <= 1'b0;
                    rsp_valid <= 1'b1;
                    state_q   <= RESP;
                end
                RESP: begin
                    rsp_valid <= 1'b0;
                    rsp_rdata <= 32'd0;
                    rsp_err   <= 1'b0;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef LSU_PERF_CNT_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        sat_inc = (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            load_cnt  <= 16'd0;
            store_cnt <= 16'd0;
            err_cnt   <= 16'd0;
        end else if (state_q == RESP) begin
            if (rsp_err)   err_cnt   <= sat_inc(err_cnt);
            else if (we_q) store_cnt <= sat_inc(store_cnt);
            else           load_cnt  <= sat_inc(load_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboarded random/directed bench for load_store_unit against a byte-array reference memory.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_A;
    logic [31:0] mem_WD;
    logic        mem_WE;
    logic [31:0] mem_RD;
`ifdef LSU_PERF_CNT_EN
    logic [15:0] load_cnt, store_cnt, err_cnt;
`endif

    load_store_unit #(.DEPTH(100), .AW(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_A      (mem_A),
        .mem_WD     (mem_WD),
        .mem_WE     (mem_WE),
        .mem_RD     (mem_RD)
`ifdef LSU_PERF_CNT_EN
        ,
        .load_cnt   (load_cnt),
        .store_cnt  (store_cnt),
        .err_cnt    (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Attached memory: combinational read, synchronous full-word write.
    logic [31:0] tbmem [0:99];
    assign mem_RD = (mem_A < 32'd100) ? tbmem[mem_A[6:0]] : 32'd0;
    always @(posedge clk) if (mem_WE && mem_A < 32'd100) tbmem[mem_A[6:0]] <= mem_WD;

    // Reference model state: plain byte array.
    logic [7:0] ref_bytes [0:399];

    typedef struct { logic [31:0] rdata; logic err; int cyc; } rsp_exp_t;
    typedef struct { logic [31:0] a; logic [31:0] d; int cyc; } wr_exp_t;
    rsp_exp_t rq[$];
    wr_exp_t  wq[$];

    int checks = 0;
    int fails  = 0;
    int acc_cnt = 0;
    int issued = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model(input logic we, input logic [1:0] sz, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wd, input int drive_cyc);
        int n, a, base;
        bit err;
        longint unsigned v;
        rsp_exp_t r;
        wr_exp_t w;
        n = 1 << sz;
        err = (sz == 2'd3) || ((addr % n) != 0) || ((addr / 4) >= 100);
        r.rdata = 32'd0;
        r.err = err;
        if (err) begin
            r.cyc = drive_cyc + 1;
        end else begin
            a = int'(addr);
            if (we) begin
                for (int i = 0; i < n; i++) ref_bytes[a + i] = wd[8*i +: 8];
                base = a - (a % 4);
                w.a = 32'(a / 4);
                w.d = {ref_bytes[base+3], ref_bytes[base+2], ref_bytes[base+1], ref_bytes[base]};
                w.cyc = drive_cyc + ((n == 4) ? 1 : 2);
                wq.push_back(w);
                r.cyc = drive_cyc + ((n == 4) ? 2 : 3);
            end else begin
                v = 0;
                for (int i = 0; i < n; i++) v = v | (longint'(ref_bytes[a + i]) << (8 * i));
                if (sgn && n < 4 && v[8*n-1]) v = v | ~((64'd1 << (8 * n)) - 64'd1);
                r.rdata = v[31:0];
                r.cyc = drive_cyc + 2;
            end
        end
        rq.push_back(r);
    endtask

    // Called #1 after a rising edge; returns #1 after the accepting edge.
    task automatic issue(input logic we, input logic [1:0] sz, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input bit hold, input bit use_model, output int acc_cyc);
        int n;
        req_valid  = 1'b1;
        req_we     = we;
        req_size   = sz;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wd;
        n = 0;
        while (!req_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!req_ready) begin
            checks++;
            fails++;
            $display("FAIL accept_timeout: req_ready got 0 expected 1 within 100 cycles");
            req_valid = 1'b0;
            acc_cyc = -1;
            return;
        end
        acc_cyc = cyc;
        issued++;
        if (use_model) model(we, sz, sgn, addr, wd, cyc);
        @(posedge clk); #1;
        if (!hold) req_valid = 1'b0;
    endtask

    always @(posedge clk) if (req_valid && req_ready) acc_cnt++;

    rsp_exp_t mon_r;
    wr_exp_t  mon_w;
    always @(negedge clk) begin
        if (rsp_valid === 1'b1) begin
            if (rq.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_rsp: rsp_valid got 1 expected 0 (cycle %0d)", cyc);
            end else begin
                mon_r = rq.pop_front();
                check("rsp_rdata", rsp_rdata, mon_r.rdata);
                check("rsp_err", 32'(rsp_err), 32'(mon_r.err));
                check("rsp_cycle", 32'(cyc), 32'(mon_r.cyc));
            end
        end
        if (mem_WE === 1'b1) begin
            if (wq.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_write: mem_WE got 1 expected 0 at A=%h (cycle %0d)", mem_A, cyc);
            end else begin
                mon_w = wq.pop_front();
                check("mem_A", mem_A, mon_w.a);
                check("mem_WD", mem_WD, mon_w.d);
                check("write_cycle", 32'(cyc), 32'(mon_w.cyc));
            end
        end
    end

    initial begin
        int acc, acc2, n;
        logic [31:0] a;
        logic [1:0] sz;

        for (int i = 0; i < 100; i++) tbmem[i] = 32'd0;
        for (int i = 0; i < 400; i++) ref_bytes[i] = 8'd0;

        repeat (3) @(posedge clk);
        #1;
        check("ready_in_reset", 32'(req_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_rdata", rsp_rdata, 32'd0);
        check("reset_rsp_err", 32'(rsp_err), 32'd0);
        check("reset_mem_A", mem_A, 32'd0);
        check("reset_mem_WD", mem_WD, 32'd0);
        check("reset_mem_WE", 32'(mem_WE), 32'd0);
        check("reset_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;

        // Directed sequence around word 2.
        issue(1'b1, 2'b10, 1'b0, 32'h8, 32'hDEADBEEF, 0, 1, acc);
        issue(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 0, 1, acc);
        issue(1'b0, 2'b00, 1'b1, 32'h9, 32'h0, 0, 1, acc);
        issue(1'b0, 2'b00, 1'b0, 32'h9, 32'h0, 0, 1, acc);
        issue(1'b0, 2'b01, 1'b1, 32'hA, 32'h0, 0, 1, acc);
        issue(1'b0, 2'b01, 1'b0, 32'h8, 32'h0, 0, 1, acc);
        issue(1'b1, 2'b00, 1'b0, 32'hB, 32'h12, 0, 1, acc);
        issue(1'b1, 2'b01, 1'b0, 32'h8, 32'h5678, 0, 1, acc);
        issue(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 0, 1, acc);
        // Error cases: misaligned word, misaligned half, illegal size, index 100.
        issue(1'b0, 2'b10, 1'b0, 32'h6, 32'h0, 0, 1, acc);
        issue(1'b1, 2'b01, 1'b0, 32'h3, 32'hFFFF, 0, 1, acc);
        issue(1'b0, 2'b11, 1'b0, 32'h0, 32'h0, 0, 1, acc);
        issue(1'b0, 2'b10, 1'b0, 32'h190, 32'h0, 0, 1, acc);
        repeat (4) @(posedge clk);
        #1;
        check("word2_after_merges", tbmem[2], 32'h12AD5678);

        // Reset landing in the WRITE cycle of a byte store must leave word 1 intact.
        issue(1'b1, 2'b10, 1'b0, 32'h4, 32'hCAFEF00D, 0, 1, acc);
        repeat (3) @(posedge clk);
        #1;
        issue(1'b1, 2'b00, 1'b0, 32'h4, 32'h000000AB, 0, 0, acc);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("ready_after_reset", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        check("word1_no_write", tbmem[1], 32'hCAFEF00D);
        issue(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 0, 1, acc);

        // Back-to-back with req_valid held: second accept one cycle after the first response.
        issue(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 1, 1, acc);
        issue(1'b1, 2'b00, 1'b0, 32'h21, 32'h77, 0, 1, acc2);
        check("b2b_accept_cycle", 32'(acc2), 32'(acc + 3));

        // Randomised traffic, sometimes holding req_valid between requests.
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 15) == 0) a = $urandom;
            else a = 32'($urandom_range(0, 419));
            sz = 2'($urandom_range(0, 3));
            issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom,
                  1'($urandom_range(0, 1)), 1, acc);
        end
        req_valid = 1'b0;

        n = 0;
        while ((rq.size() != 0 || wq.size() != 0) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        check("pending_rsp", 32'(rq.size()), 32'd0);
        check("pending_wr", 32'(wq.size()), 32'd0);
        check("accept_count", 32'(acc_cnt), 32'(issued));

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
